linked_list_arbiter: RTL and testbench

LINKED_LIST_ARBITER -- requirements
Module: linked_list_arbiter

---
 rtl/linked_list_arbiter.sv | 159 +++++++++++++++
 tb/tb_linked_list_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linked_list_arbiter.sv
// Round-robin arbiter that serialises requester commands onto a single
// linked-list command port and returns each completion to its requester.
module linked_list_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8,
    parameter int TIMEOUT    = 64,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1),
    localparam int GID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*3-1:0]             req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic [ADDR_WIDTH-1:0]            resp_next_addr,
    output logic                             resp_fault,
    output logic                             resp_timeout,
    output logic [2:0]                       ll_op,
    output logic                             ll_op_start,
    output logic [DATA_WIDTH-1:0]            ll_data_in,
    output logic [ADDR_WIDTH-1:0]            ll_addr_in,
    input  logic                             ll_op_done,
    input  logic [DATA_WIDTH-1:0]            ll_data_out,
    input  logic [ADDR_WIDTH-1:0]            ll_next_node_addr,
    input  logic                             ll_fault,
    output logic                             busy,
    output logic [GID_WIDTH-1:0]             grant_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [GID_WIDTH-1:0]  last_grant;
    logic [CNT_WIDTH-1:0]  tmo_cnt;
    logic [2:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    logic [2:0]            op_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    logic                  grant_found;
    logic [GID_WIDTH-1:0]  grant_idx;
    int                    cand;
    logic                  grant_legal;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]     = req_op[3*gi +: 3];
            assign data_arr[gi]   = req_data[DATA_WIDTH*gi +: DATA_WIDTH];
            assign addr_arr[gi]   = req_addr[ADDR_WIDTH*gi +: ADDR_WIDTH];
            // Ready is combinational so the requester sees it in the grant cycle.
            assign req_ready[gi]  = !rst && (state == IDLE) && grant_found &&
                                    (grant_idx == GID_WIDTH'(gi));
            assign resp_valid[gi] = (state == RESP) && (grant_id == GID_WIDTH'(gi));
        end
    endgenerate

    // Walk downward so the candidate closest after last_grant is assigned last and wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = GID_WIDTH'(cand);
            end
        end
    end

    assign grant_legal = (op_arr[grant_idx] != 3'd4) && (op_arr[grant_idx] != 3'd6);

    assign ll_op      = cmd_op;
    assign ll_data_in = cmd_data;
    assign ll_addr_in = cmd_addr;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ll_op_start    <= 1'b0;
            resp_fault     <= 1'b0;
            resp_timeout   <= 1'b0;
            resp_data      <= '0;
            resp_next_addr <= '0;
            cmd_op         <= '0;
            cmd_data       <= '0;
            cmd_addr       <= '0;
            grant_id       <= '0;
            last_grant     <= GID_WIDTH'(NUM_REQ - 1);
            tmo_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cmd_op     <= op_arr[grant_idx];
                        cmd_data   <= data_arr[grant_idx];
                        cmd_addr   <= addr_arr[grant_idx];
                        grant_id   <= grant_idx;
                        last_grant <= grant_idx;
                        tmo_cnt    <= '0;
                        if (grant_legal) begin
                            state       <= BUSY;
                            ll_op_start <= 1'b1;
                        end else begin
                            // Illegal op never reaches the list; answer straight away.
                            state          <= RESP;
                            resp_fault     <= 1'b1;
                            resp_timeout   <= 1'b0;
                            resp_data      <= '0;
                            resp_next_addr <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (ll_op_done) begin
                        state          <= RESP;
                        ll_op_start    <= 1'b0;
                        resp_data      <= ll_data_out;
                        resp_next_addr <= ll_next_node_addr;
                        resp_fault     <= ll_fault;
                        resp_timeout   <= 1'b0;
                    end else if (tmo_cnt == CNT_LAST) begin
                        state          <= RESP;
                        ll_op_start    <= 1'b0;
                        resp_data      <= '0;
                        resp_next_addr <= '0;
                        resp_fault     <= 1'b1;
                        resp_timeout   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    ll_op_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linked_list_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, list commands and
// responses into queues; a negedge monitor pops and compares them.
module tb_linked_list_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic [3:0] addr;
    } cmd_t;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic [3:0] nxt;
        logic       fault;
        logic       tmo;
        logic       chk_data;
        int         lat;
        int         starts;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR*3-1:0]    req_op = '0;
    logic [NR*DW-1:0]   req_data = '0;
    logic [NR*AW-1:0]   req_addr = '0;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      resp_valid;
    logic [DW-1:0]      resp_data;
    logic [AW-1:0]      resp_next_addr;
    logic               resp_fault;
    logic               resp_timeout;
    logic [2:0]         ll_op;
    logic               ll_op_start;
    logic [DW-1:0]      ll_data_in;
    logic [AW-1:0]      ll_addr_in;
    logic               ll_op_done = 1'b0;
    logic [DW-1:0]      ll_data_out = '0;
    logic [AW-1:0]      ll_next_node_addr = '0;
    logic               ll_fault = 1'b0;
    logic               busy;
    logic [1:0]         grant_id;

    int total = 0;
    int bad = 0;

    cmd_t dq [NR][$];
    int   gq [$];
    cmd_t llq [$];
    exp_t rq [$];

    logic [NR-1:0] rdy_seen = '0;
    int   mdl_lat = 1;
    bit   hang = 0;
    logic [7:0] mem_d [16];
    logic [3:0] mem_n [16];

    linked_list_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_next_addr(resp_next_addr), .resp_fault(resp_fault), .resp_timeout(resp_timeout),
        .ll_op(ll_op), .ll_op_start(ll_op_start), .ll_data_in(ll_data_in), .ll_addr_in(ll_addr_in),
        .ll_op_done(ll_op_done), .ll_data_out(ll_data_out), .ll_next_node_addr(ll_next_node_addr),
        .ll_fault(ll_fault), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Requester driver: hold each command until its ready pulse was seen.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++)
                if (rdy_seen[i] && dq[i].size() > 0) void'(dq[i].pop_front());
            for (int i = 0; i < NR; i++) begin
                if (dq[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_op[3*i +: 3]    = dq[i][0].op;
                    req_data[DW*i +: DW] = dq[i][0].data;
                    req_addr[AW*i +: AW] = dq[i][0].addr;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // List model: done after mdl_lat start-high cycles; op 0 reads the node table,
    // other ops return inverted data, addr+1, and fault for op 7.
    initial begin
        int mcnt;
        mcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || !ll_op_start || ll_op_done) begin
                ll_op_done = 1'b0;
                mcnt = 0;
            end else if (!hang) begin
                mcnt++;
                if (mcnt >= mdl_lat) begin
                    ll_op_done = 1'b1;
                    if (ll_op == 3'd0) begin
                        ll_data_out       = mem_d[ll_addr_in];
                        ll_next_node_addr = mem_n[ll_addr_in];
                        ll_fault          = 1'b0;
                    end else begin
                        ll_data_out       = ll_data_in ^ 8'hFF;
                        ll_next_node_addr = ll_addr_in + 4'd1;
                        ll_fault          = (ll_op == 3'd7);
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int   cyc, grant_cyc, start_cnt, g;
        logic prev_start;
        cmd_t cur;
        exp_t e;
        cyc = 0; grant_cyc = 0; start_cnt = 0; prev_start = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rdy_seen = rst ? '0 : req_ready;
            if (!rst) begin
                if (req_ready != '0) begin
                    if (gq.size() == 0) begin
                        check("unexpected_grant", int'(req_ready), 0);
                    end else begin
                        g = gq.pop_front();
                        check("grant", int'(req_ready), 1 << g);
                        $display("grant req=%0d ready=%b", g, req_ready);
                    end
                    grant_cyc = cyc;
                    start_cnt = 0;
                end
                if (ll_op_start) begin
                    start_cnt++;
                    if (!prev_start) begin
                        if (llq.size() == 0) check("unexpected_ll_start", 1, 0);
                        else cur = llq.pop_front();
                    end
                    check("ll_cmd", int'({ll_op, ll_data_in, ll_addr_in}), int'(cur));
                end
                if (resp_valid != '0) begin
                    if (rq.size() == 0) begin
                        check("unexpected_resp", int'(resp_valid), 0);
                    end else begin
                        e = rq.pop_front();
                        $display("resp req=%0d data=%h next=%0d fault=%b tmo=%b lat=%0d",
                                 e.req, resp_data, resp_next_addr, resp_fault, resp_timeout,
                                 cyc - grant_cyc);
                        check("resp_valid", int'(resp_valid), 1 << e.req);
                        check("resp_grant_id", int'(grant_id), e.req);
                        check("resp_fault", int'(resp_fault), int'(e.fault));
                        check("resp_timeout", int'(resp_timeout), int'(e.tmo));
                        check("resp_latency", cyc - grant_cyc, e.lat);
                        check("ll_start_cycles", start_cnt, e.starts);
                        if (e.chk_data) begin
                            check("resp_data", int'(resp_data), int'(e.data));
                            check("resp_next", int'(resp_next_addr), int'(e.nxt));
                        end
                    end
                end
            end
            prev_start = ll_op_start;
        end
    end

    task automatic issue(input int r, input logic [2:0] op, input logic [7:0] d,
                         input logic [3:0] a, input logic [7:0] ed, input logic [3:0] en,
                         input logic ef, input logic et, input logic chk, input int lat,
                         input int starts, input bit want_resp);
        cmd_t c;
        exp_t e;
        c.op = op; c.data = d; c.addr = a;
        dq[r].push_back(c);
        gq.push_back(r);
        if (op != 3'd4 && op != 3'd6) llq.push_back(c);
        if (want_resp) begin
            e.req = r; e.data = ed; e.nxt = en; e.fault = ef; e.tmo = et;
            e.chk_data = chk; e.lat = lat; e.starts = starts;
            rq.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while ((rq.size() != 0 || gq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin mem_d[i] = 8'h00; mem_n[i] = 4'd0; end
        mem_d[3] = 8'hA7; mem_n[3] = 4'd5;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_ll_start", int'(ll_op_start), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_fault", int'(resp_fault), 0);
        check("rst_ll_op", int'(ll_op), 0);
        check("rst_resp_data", int'(resp_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // Contention: grant order 0,1,2,3,0
        mdl_lat = 1;
        issue(0, 3'd1, 8'h01, 4'd0, 8'hFE, 4'd1, 1'b0, 1'b0, 1'b1, 2, 1, 1);
        issue(1, 3'd2, 8'h02, 4'd1, 8'hFD, 4'd2, 1'b0, 1'b0, 1'b1, 2, 1, 1);
        issue(2, 3'd3, 8'h03, 4'd2, 8'hFC, 4'd3, 1'b0, 1'b0, 1'b1, 2, 1, 1);
        issue(3, 3'd5, 8'h04, 4'd3, 8'hFB, 4'd4, 1'b0, 1'b0, 1'b1, 2, 1, 1);
        issue(0, 3'd7, 8'h05, 4'd4, 8'hFA, 4'd5, 1'b1, 1'b0, 1'b1, 2, 1, 1);
        wait_done(200, "contention");

        // Single insert from requester 2, two-cycle list op
        mdl_lat = 2;
        issue(2, 3'd1, 8'h5A, 4'd0, 8'hA5, 4'd1, 1'b0, 1'b0, 1'b1, 3, 2, 1);
        wait_done(100, "single");

        // Read data path
        mdl_lat = 3;
        issue(1, 3'd0, 8'h00, 4'd3, 8'hA7, 4'd5, 1'b0, 1'b0, 1'b1, 4, 3, 1);
        wait_done(100, "read");

        // Illegal ops never start the list
        issue(0, 3'd6, 8'h33, 4'd1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1);
        wait_done(100, "illegal6");
        issue(0, 3'd4, 8'h34, 4'd2, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1);
        wait_done(100, "illegal4");

        // Timeout, then a normal request
        hang = 1;
        issue(3, 3'd2, 8'h11, 4'd2, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 65, 64, 1);
        wait_done(300, "timeout");
        hang = 0;
        mdl_lat = 1;
        issue(1, 3'd3, 8'h10, 4'd4, 8'hEF, 4'd5, 1'b0, 1'b0, 1'b1, 2, 1, 1);
        wait_done(100, "after_timeout");

        // Reset in the middle of a list op
        hang = 1;
        issue(2, 3'd1, 8'h77, 4'd6, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        n = 0;
        while (!ll_op_start && n < 50) begin @(negedge clk); n++; end
        check("midop_started", int'(ll_op_start), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop_ll_start", int'(ll_op_start), 0);
        check("midop_busy", int'(busy), 0);
        check("midop_resp_valid", int'(resp_valid), 0);
        for (int i = 0; i < NR; i++) dq[i].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hang = 0;
        mdl_lat = 1;
        issue(0, 3'd1, 8'h21, 4'd0, 8'hDE, 4'd1, 1'b0, 1'b0, 1'b1, 2, 1, 1);
        issue(3, 3'd1, 8'h20, 4'd7, 8'hDF, 4'd8, 1'b0, 1'b0, 1'b1, 2, 1, 1);
        wait_done(100, "after_reset");

        check("leftover_ll", llq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got stuck want finish");
        $fatal(1, "watchdog");
    end

endmodule
